// File: rtl/iq_deframer.sv
// iq_deframer: hunts for a fixed header in a BPSK/QPSK hard-decision bit
// stream, collects a fixed-length payload plus an additive checksum byte and
// reports good frames (data_o/data_valid) or bad frames (chk_err).
module iq_deframer #(
    parameter int                    HEADER_W   = 8,
    parameter logic [HEADER_W-1:0]   HEADER     = 8'hCC,
    parameter int                    DATA_BYTES = 4,
    parameter int                    COUNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_en,
    input  logic                      mode,
    input  logic                      sym_valid,
    input  logic                      sym_i,
    input  logic                      sym_q,
    output logic [DATA_BYTES*8-1:0]   data_o,
    output logic                      data_valid,
    output logic                      header_flag,
    output logic                      chk_err,
    output logic [COUNT_W-1:0]        frame_cnt,
    output logic [COUNT_W-1:0]        err_cnt,
    output logic                      busy
);

    // Payload bits plus the trailing checksum byte.
    localparam int FRAME_BITS = DATA_BYTES * 8 + 8;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic {HUNT = 1'b0, PAYLOAD = 1'b1} state_t;

    state_t                  state, state_n;
    logic [HEADER_W-1:0]     hunt, hunt_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [FRAME_BITS-1:0]   sh, sh_n;
    logic                    mode_l, mode_n;
    logic [DATA_BYTES*8-1:0] data_n;
    logic                    hdr_n, good_n, bad_n;
    logic                    two_bits, b;

    // Sum of payload bytes, modulo 256.
    function automatic logic [7:0] csum(input logic [DATA_BYTES*8-1:0] p);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < DATA_BYTES; i++) s = s + p[i*8 +: 8];
        return s;
    endfunction

    // Next state: walk the one or two bits of the symbol in order, so a
    // header match or a frame end on sym_i hands sym_q to the other state.
    always_comb begin
        state_n  = state;
        hunt_n   = hunt;
        cnt_n    = cnt;
        sh_n     = sh;
        mode_n   = mode_l;
        data_n   = data_o;
        hdr_n    = 1'b0;
        good_n   = 1'b0;
        bad_n    = 1'b0;
        b        = 1'b0;
        // The symbol's width is fixed by the state it arrives in: live mode
        // while hunting, the mode latched at the header while in a frame.
        two_bits = (state == HUNT) ? mode : mode_l;
        if (!rx_en) begin
            state_n = HUNT;
            hunt_n  = '0;
            cnt_n   = '0;
            sh_n    = '0;
        end else if (sym_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0 || two_bits) begin
                    b = (k == 0) ? sym_i : sym_q;
                    if (state_n == HUNT) begin
                        hunt_n = {hunt_n[HEADER_W-2:0], b};
                        if (hunt_n == HEADER) begin
                            state_n = PAYLOAD;
                            hdr_n   = 1'b1;
                            cnt_n   = '0;
                            sh_n    = '0;
                            mode_n  = mode;
                        end
                    end else begin
                        sh_n  = {sh_n[FRAME_BITS-2:0], b};
                        cnt_n = cnt_n + 1'b1;
                        if (cnt_n == CNT_W'(FRAME_BITS)) begin
                            if (csum(sh_n[FRAME_BITS-1:8]) == sh_n[7:0]) begin
                                good_n = 1'b1;
                                data_n = sh_n[FRAME_BITS-1:8];
                            end else begin
                                bad_n = 1'b1;
                            end
                            state_n = HUNT;
                            hunt_n  = '0;
                            cnt_n   = '0;
                        end
                    end
                end
            end
        end
    end

    // Register state, datapath, pulses and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            hunt        <= '0;
            cnt         <= '0;
            sh          <= '0;
            mode_l      <= 1'b0;
            data_o      <= '0;
            data_valid  <= 1'b0;
            header_flag <= 1'b0;
            chk_err     <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_n;
            hunt        <= hunt_n;
            cnt         <= cnt_n;
            sh          <= sh_n;
            mode_l      <= mode_n;
            data_o      <= data_n;
            data_valid  <= good_n;
            header_flag <= hdr_n;
            chk_err     <= bad_n;
            if (good_n && frame_cnt != {COUNT_W{1'b1}}) frame_cnt <= frame_cnt + 1'b1;
            if (bad_n && err_cnt != {COUNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign busy = (state == PAYLOAD);

endmodule

// File: tb/tb_iq_deframer.sv
// Directed bench for iq_deframer with a scoreboard of expected frame results.
module tb_iq_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b1, rst2 = 1'b1;
    logic        rx_en = 1'b0, rx_en2 = 1'b0;
    logic        mode = 1'b0, sym_valid = 1'b0, sym_i = 1'b0, sym_q = 1'b0;
    logic [31:0] data_o, data_o2;
    logic        data_valid, header_flag, chk_err, busy;
    logic        data_valid2, header_flag2, chk_err2, busy2;
    logic [15:0] frame_cnt, err_cnt;
    logic [1:0]  frame_cnt2, err_cnt2;

    int checks = 0, passed = 0;
    int dv_cnt = 0, ce_cnt = 0, hf_cnt = 0;

    typedef struct {logic good; logic [31:0] data;} exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] last_good = '0;

    iq_deframer dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .mode(mode), .sym_valid(sym_valid),
        .sym_i(sym_i), .sym_q(sym_q), .data_o(data_o), .data_valid(data_valid),
        .header_flag(header_flag), .chk_err(chk_err), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .busy(busy)
    );

    iq_deframer #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .rx_en(rx_en2), .mode(mode), .sym_valid(sym_valid),
        .sym_i(sym_i), .sym_q(sym_q), .data_o(data_o2), .data_valid(data_valid2),
        .header_flag(header_flag2), .chk_err(chk_err2), .frame_cnt(frame_cnt2),
        .err_cnt(err_cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [47:0] mk(input logic [31:0] d, input logic [7:0] cs);
        return {8'hCC, d, cs};
    endfunction

    function automatic logic [7:0] sum8(input logic [31:0] d);
        return d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

    task automatic push_good(input logic [31:0] d);
        sb.push_back('{1'b1, d});
        last_good = d;
    endtask

    task automatic push_bad();
        sb.push_back('{1'b0, last_good});
    endtask

    task automatic sym(input logic i, input logic q);
        @(negedge clk);
        sym_valid = 1'b1; sym_i = i; sym_q = q;
        @(posedge clk);
        #1 sym_valid = 1'b0;
    endtask

    task automatic send_bpsk(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) sym(f[i], 1'(($urandom_range(1))));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b0;
        last_good = '0;
    endtask

    // Scoreboard: every result pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (header_flag) hf_cnt++;
        if (data_valid || chk_err) begin
            if (data_valid) dv_cnt++;
            if (chk_err) ce_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", {data_valid, chk_err}, 2'b00);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", {data_valid, chk_err}, {e.good, !e.good});
                chk("sb_data", data_o, e.data);
            end
        end
    end

    initial begin
        logic [47:0] f;
        logic [97:0] s;
        int          dv0, hf0;

        // Reset state
        #12;
        chk("rst_data", data_o, 0);
        chk("rst_pulses", {data_valid, header_flag, chk_err, busy}, 0);
        chk("rst_cnts", {frame_cnt, err_cnt}, 0);
        rst = 1'b0;
        rx_en = 1'b1;
        idle(2);

        // BPSK good frame; mode toggled mid-payload must be ignored
        f = mk(32'h12345678, 8'h14);
        for (int i = 47; i >= 41; i--) sym(f[i], 1'b0);
        chk("hdr_early", header_flag, 0);
        sym(f[40], 1'b0);
        chk("hdr_flag", header_flag, 1);
        chk("busy_payload", busy, 1);
        push_good(32'h12345678);
        mode = 1'b1;
        for (int i = 39; i >= 0; i--) sym(f[i], 1'(($urandom_range(1))));
        mode = 1'b0;
        chk("dv_pulse", data_valid, 1);
        chk("frame_cnt1", frame_cnt, 1);
        chk("busy_after", busy, 0);
        idle(1);
        chk("dv_one_cycle", data_valid, 0);
        idle(2);
        chk("dv_count1", dv_cnt, 1);
        chk("hf_count1", hf_cnt, 1);

        // Bad checksum after a fresh reset
        do_rst();
        dv0 = dv_cnt;
        push_bad();
        send_bpsk(mk(32'h12345678, 8'h15));
        chk("ce_pulse", chk_err, 1);
        idle(3);
        chk("err_cnt1", err_cnt, 1);
        chk("bad_data_hold", data_o, 0);
        chk("bad_no_dv", dv_cnt, dv0);
        chk("ce_count", ce_cnt, 1);

        // QPSK: leading 0, two back-to-back frames, trailing sym_q starts frame 2
        do_rst();
        mode = 1'b1;
        hf0 = hf_cnt;
        s = {1'b0, mk(32'h12345678, 8'h14), mk(32'hA1B2C3D4, sum8(32'hA1B2C3D4)), 1'b0};
        push_good(32'h12345678);
        push_good(32'hA1B2C3D4);
        for (int i = 97; i > 0; i -= 2) sym(s[i], s[i-1]);
        mode = 1'b0;
        idle(3);
        chk("qpsk_hf", hf_cnt - hf0, 2);
        chk("qpsk_frames", frame_cnt, 2);
        chk("qpsk_data", data_o, 32'hA1B2C3D4);

        // Reset mid-payload, then a full frame
        do_rst();
        dv0 = dv_cnt;
        f = mk(32'hDEADBEEF, sum8(32'hDEADBEEF));
        for (int i = 47; i >= 20; i--) sym(f[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        last_good = '0;
        push_good(32'h0BADF00D);
        send_bpsk(mk(32'h0BADF00D, sum8(32'h0BADF00D)));
        idle(3);
        chk("rst_mid_dv", dv_cnt - dv0, 1);
        chk("rst_mid_frames", frame_cnt, 1);
        chk("rst_mid_err", err_cnt, 0);

        // rx_en low mid-payload drops the frame silently
        f = mk(32'h55AA33CC, 8'h00);
        for (int i = 47; i >= 30; i--) sym(f[i], 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rx_en = 1'b0; sym_valid = 1'b1; sym_i = 1'(($urandom_range(1)));
            @(posedge clk);
            #1;
            chk("rxen_busy", busy, 0);
        end
        sym_valid = 1'b0;
        rx_en = 1'b1;
        push_good(32'hCAFE0001);
        send_bpsk(mk(32'hCAFE0001, sum8(32'hCAFE0001)));
        idle(3);
        chk("rxen_frames", frame_cnt, 2);
        chk("rxen_err", err_cnt, 0);
        chk("rxen_data", data_o, 32'hCAFE0001);

        // Two-bit counters saturate at 3
        rx_en = 1'b0;
        rst2 = 1'b0;
        rx_en2 = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            send_bpsk(mk(32'h01020304, 8'h0A));
            idle(1);
            chk("sat_frame_cnt", frame_cnt2, (n > 3) ? 3 : n);
        end
        chk("sat_err_cnt", err_cnt2, 0);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/iq_deframer.md
IQ_DEFRAMER -- requirements
Module: iq_deframer

Interface
REQ-001 Parameter HEADER, default 8'hCC: frame header pattern, transmitted MSB first.
REQ-002 Parameter HEADER_W, default 8: header width in bits, range 2..32.
REQ-003 Parameter DATA_BYTES, default 4: payload length in bytes, range 1..16.
REQ-004 Parameter COUNT_W, default 16: width of the frame and error counters.
REQ-005 clk  in  1: the single clock; all logic is on the rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 rx_en  in  1: receiver enable.
REQ-008 mode  in  1: 0 = BPSK, using the sym_i bit only; 1 = QPSK, using sym_i then sym_q.
REQ-009 sym_valid  in  1: decision strobe; sym_i/sym_q are sampled only when it is high.
REQ-010 sym_i, sym_q  in  1 each: hard-decided I and Q bits.
REQ-011 data_o  out  DATA_BYTES*8: last good payload, with the first-received byte at the MSBs.
REQ-012 data_valid  out  1: one-cycle pulse when data_o updates.
REQ-013 header_flag  out  1: one-cycle pulse on header detection.
REQ-014 chk_err  out  1: one-cycle pulse when a frame fails its checksum.
REQ-015 frame_cnt, err_cnt  out  COUNT_W each: counts of good frames and bad frames.
REQ-016 busy  out  1: high while in PAYLOAD.

Function
REQ-017 Frame format SHALL be HEADER_W header bits, then DATA_BYTES payload bytes, then one checksum byte; all fields are sent MSB first; checksum = sum of the payload bytes mod 256.
REQ-018 Bit order SHALL be sym_i only in BPSK; in QPSK, sym_i is processed before sym_q; each sym_valid cycle accepts 1 bit in BPSK and 2 bits in QPSK.
REQ-019 FSM SHALL have two states: HUNT and PAYLOAD.
REQ-020 HUNT: each accepted bit SHALL shift into a HEADER_W-bit hunt register, with the comparison against HEADER made after every individual bit.
REQ-021 HUNT: on a match, the FSM SHALL go to PAYLOAD, pulse header_flag, clear the bit counter, and latch mode; in QPSK, if the match occurs on the sym_i bit, sym_q SHALL be the first payload bit.
REQ-022 PAYLOAD SHALL collect DATA_BYTES*8+8 bits; header matching SHALL NOT run in PAYLOAD, and a mode change SHALL be ignored until the next HUNT.
REQ-023 On the final bit, the checksum SHALL be compared.
 - Match: data_o updates, data_valid pulses, frame_cnt increments.
 - Mismatch: data_o holds, chk_err pulses, err_cnt increments.
 - Either case: the FSM returns to HUNT with the hunt register cleared to 0.
REQ-024 In QPSK, if the final bit is a sym_i bit, that symbol's sym_q bit SHALL be shifted into the freshly cleared hunt register.
REQ-025 Latency: header_flag, data_valid and chk_err SHALL be registered, asserting the cycle after the sym_valid cycle that carries the deciding bit.
REQ-026 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 While rx_en is low:
 - sym_valid SHALL be ignored.
 - The FSM SHALL be forced to HUNT; the hunt register, bit counter and partial payload are cleared.
 - No pulses are issued.
 - data_o and the counters hold.
REQ-028 A frame aborted by rx_en or rst SHALL produce neither a data_valid nor a chk_err pulse.

Reset
REQ-029 On rst high, SHALL asynchronously set: state = HUNT, hunt register/bit counter/payload = 0, data_o = 0, data_valid = header_flag = chk_err = busy = 0, frame_cnt = err_cnt = 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL hunt from the next sym_valid.

Verification (HEADER=8'hCC, DATA_BYTES=4, COUNT_W=16 unless noted)
REQ-031 BPSK: bits 0xCC,12,34,56,78,14 -> header_flag 1 cycle after bit 8; data_o=0x12345678, data_valid one pulse, frame_cnt=1, busy low afterwards.
REQ-032 Same frame with checksum 0x15 -> chk_err one pulse, err_cnt=1, data_o stays 0, data_valid never high.
REQ-033 QPSK with a single leading 0 bit (header completes on sym_i) -> header_flag, then data_o=0x12345678; the trailing sym_q bit enters the hunt register; a back-to-back second frame is still detected.
REQ-034 rst pulse after 20 payload bits, then a full frame -> exactly one data_valid, frame_cnt=1, no chk_err.
REQ-035 rx_en low for 3 cycles mid-payload, then a full frame -> first frame is silently dropped, second frame is good, err_cnt=0.
REQ-036 COUNT_W=2: five good frames -> frame_cnt reads 3 after the 3rd, 4th and 5th frames.
